serializa_datos: RTL

- Transmit side of the 64-bit serial frame link: turns one 64-bit parallel word into the bit-serial data/strobe pair consumed by the frame receiver (data line plus "enviando" strobe).
- The receiver samples on its own ~200 kHz derived clock (period 252 CLK cycles) and captures one bit per rising edge of the strobe.
- This block therefore paces every strobe phase to span more than one receiver sample period.
- It sits between the frame-producing logic and the receiver, on the same CLK.

---
 rtl/serializa_datos_pkg.sv | 20 ++
 rtl/serializa_datos_contador_fase.sv | 35 +++
 rtl/serializa_datos.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serializa_datos_pkg.sv
// Shared constants for the 64-bit serial frame transmitter: state encoding,
// frame size and the receiver timing it has to respect.
package serializa_datos_pkg;

    localparam int FRAME_BITS     = 64;
    localparam int RX_SLOW_PERIOD = 252;
    // A strobe phase must outlast one receiver sample period with margin.
    localparam int MIN_STROBE     = 260;

    localparam logic [2:0] REPOSO = 3'd0;
    localparam logic [2:0] PREP   = 3'd1;
    localparam logic [2:0] ALTO   = 3'd2;
    localparam logic [2:0] BAJO   = 3'd3;
    localparam logic [2:0] PAUSA  = 3'd4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serializa_datos_contador_fase.sv
// Loadable down-counter with a terminal-count flag; times every phase of the
// serial frame (setup, strobe high, strobe low, inter-frame gap).
module contador_fase #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         carga_i,
    input  logic [W-1:0] valor_i,
    output logic         fin_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Loading N-1 gives a phase exactly N cycles long; parks at zero when idle.
    always_comb begin
        cnt_d = cnt_q;
        if (carga_i) begin
            cnt_d = valor_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fin_o = (cnt_q == '0);

endmodule

// File: rtl/serializa_datos.sv
// Bit-serial transmitter: shifts a parallel word out LSB first on DS with a
// slow "enviando" strobe paced for the ~200 kHz frame receiver.
module serializa_datos
    import serializa_datos_pkg::*;
#(
    parameter int T_SETUP = 16,
    parameter int T_ALTO  = 300,
    parameter int T_BAJO  = 300,
    parameter int T_GAP   = 100000,
    parameter int N_BITS  = FRAME_BITS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_BITS-1:0] datos,
    input  logic              cargar,
    output logic              listo,
    output logic              DS,
    output logic              enviando,
    output logic              ocupado
);

    localparam int T_MAX = max_int(max_int(T_SETUP, T_ALTO), max_int(T_BAJO, T_GAP));
    localparam int CNT_W = $clog2(T_MAX + 1);

    if (T_ALTO < MIN_STROBE || T_BAJO < MIN_STROBE) begin : g_err_strobe
        $error("serializa_datos: T_ALTO and T_BAJO must be >= %0d", MIN_STROBE);
    end
    if (T_SETUP < 1 || T_GAP < 1) begin : g_err_fase
        $error("serializa_datos: T_SETUP and T_GAP must be >= 1");
    end
    if (N_BITS < 1 || N_BITS > 64) begin : g_err_bits
        $error("serializa_datos: N_BITS must be within 1..64");
    end

    logic [2:0]        state_q, state_d;
    logic [N_BITS-1:0] shreg_q, shreg_d;
    logic [5:0]        bit_q, bit_d;
    logic              env_q, env_d;
    logic              ocu_q, ocu_d;
    logic              carga;
    logic [CNT_W-1:0]  valor;
    logic              fin;

    contador_fase #(
        .W (CNT_W)
    ) u_fase (
        .clk_i   (CLK),
        .rst_i   (RST),
        .carga_i (carga),
        .valor_i (valor),
        .fin_o   (fin)
    );

    // DS is the LSB of the shift register, so it only moves when the
    // register loads or shifts, i.e. on entry to PREP.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        env_d   = env_q;
        ocu_d   = ocu_q;
        carga   = 1'b0;
        valor   = '0;
        case (state_q)
            REPOSO: begin
                if (cargar) begin
                    shreg_d = datos;
                    bit_d   = '0;
                    ocu_d   = 1'b1;
                    carga   = 1'b1;
                    valor   = CNT_W'(T_SETUP - 1);
                    state_d = PREP;
                end
            end
            PREP: begin
                if (fin) begin
                    env_d   = 1'b1;
                    carga   = 1'b1;
                    valor   = CNT_W'(T_ALTO - 1);
                    state_d = ALTO;
                end
            end
            ALTO: begin
                if (fin) begin
                    env_d   = 1'b0;
                    carga   = 1'b1;
                    valor   = CNT_W'(T_BAJO - 1);
                    state_d = BAJO;
                end
            end
            BAJO: begin
                if (fin) begin
                    carga = 1'b1;
                    if (bit_q == 6'(N_BITS - 1)) begin
                        valor   = CNT_W'(T_GAP - 1);
                        state_d = PAUSA;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 6'd1;
                        valor   = CNT_W'(T_SETUP - 1);
                        state_d = PREP;
                    end
                end
            end
            PAUSA: begin
                if (fin) begin
                    ocu_d   = 1'b0;
                    state_d = REPOSO;
                end
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= REPOSO;
            shreg_q <= '0;
            bit_q   <= '0;
            env_q   <= 1'b0;
            ocu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            env_q   <= env_d;
            ocu_q   <= ocu_d;
        end
    end

    assign listo    = (state_q == REPOSO);
    assign DS       = shreg_q[0];
    assign enviando = env_q;
    assign ocupado  = ocu_q;

endmodule
